// File: rtl/led_sweep_pkg.sv
// Shared types and constants for the LED sweep block.
// The LED_SWEEP_WRAP_EN macro (see led_sweep.sv) selects wrap-around instead of bounce.
package led_sweep_pkg;

    typedef enum logic [1:0] {IDLE, UP, DOWN} sweep_state_t;

    localparam int NUM_LEDS = 8;
    localparam int LEVEL_W  = 3;

    function automatic logic [NUM_LEDS-1:0] pos_onehot(input logic [2:0] pos);
        return NUM_LEDS'(1) << pos;
    endfunction

endpackage

// File: rtl/sweep_prescaler.sv
// Step-rate prescaler: counts 0..period-1 while enabled and pulses tick on the last count.
module sweep_prescaler #(
    parameter int CNT_W = 25
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W:0]   period,
    output logic             tick
);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = ({1'b0, r_count} == (period - (CNT_W+1)'(1)));
    assign tick   = enable & w_last;

    // clear outranks enable so a level change restarts the period on the same edge
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_sweep.sv
// Moving one-hot LED sweep with programmable speed level; bounces between the ends.
// Define LED_SWEEP_WRAP_EN to wrap from position 7 back to 0 instead of bouncing.
module led_sweep
    import led_sweep_pkg::*;
#(
    parameter int DIV_BASE = 25_000_000,
    parameter int LEVELS   = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                RUN,
    input  logic                HOLD,
    input  logic                SPEED_UP,
    input  logic                LEVEL_CLR,
    output logic [NUM_LEDS-1:0] LEDS,
    output logic                STEP,
    output logic [LEVEL_W-1:0]  LEVEL
);

    localparam int                 CNT_W   = $clog2(DIV_BASE);
    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVELS - 1);

`ifdef LED_SWEEP_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    function automatic logic [CNT_W:0] period_of(input logic [LEVEL_W-1:0] lvl);
        int p;
        p = DIV_BASE >> lvl;
        if (p < 1) p = 1;
        return (CNT_W+1)'(p);
    endfunction

    sweep_state_t        r_state;
    logic [2:0]          r_pos;
    logic [NUM_LEDS-1:0] r_leds;
    logic                r_step;
    logic [LEVEL_W-1:0]  r_level;

    logic [CNT_W:0]      w_period;
    logic                w_enable;
    logic                w_clear;
    logic                w_tick;
    logic [2:0]          w_pos_nxt;

    assign w_period  = period_of(r_level);
    assign w_enable  = RUN && !HOLD && (r_state != IDLE);
    assign w_clear   = !RUN || (r_state == IDLE) || SPEED_UP || LEVEL_CLR;
    // In the wrap build UP at 7 rolls over to 0 through the 3-bit add
    assign w_pos_nxt = (r_state == DOWN) ? r_pos - 3'd1 : r_pos + 3'd1;

    sweep_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clear  (w_clear),
        .enable (w_enable),
        .period (w_period),
        .tick   (w_tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_leds  <= pos_onehot(3'd0);
            r_step  <= 1'b0;
            r_level <= '0;
        end else begin
            r_step <= 1'b0;

            if (LEVEL_CLR) begin
                r_level <= '0;
            end else if (SPEED_UP && (r_level != LVL_MAX)) begin
                r_level <= r_level + LEVEL_W'(1);
            end

            // RUN low beats HOLD and any step due on this edge
            if (!RUN) begin
                r_state <= IDLE;
                r_pos   <= '0;
                r_leds  <= pos_onehot(3'd0);
            end else begin
                case (r_state)
                    IDLE: r_state <= UP;
                    UP, DOWN: begin
                        if (w_tick) begin
                            r_pos  <= w_pos_nxt;
                            r_leds <= pos_onehot(w_pos_nxt);
                            r_step <= 1'b1;
                            if (!WRAP && (r_state == UP) && (w_pos_nxt == 3'd7)) begin
                                r_state <= DOWN;
                            end else if ((r_state == DOWN) && (w_pos_nxt == 3'd0)) begin
                                r_state <= UP;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign LEDS  = r_leds;
    assign STEP  = r_step;
    assign LEVEL = r_level;

endmodule

// File: tb/tb_led_sweep.sv
// Randomized scoreboard bench for led_sweep (DIV_BASE=8, LEVELS=4) against a timing-based model.
module tb_led_sweep;

    localparam int DIV_BASE = 8;
    localparam int LEVELS   = 4;
`ifdef LED_SWEEP_WRAP_EN
    localparam int SEQ = 8;
`else
    localparam int SEQ = 14;
`endif

    logic       clk = 1'b0;
    logic       RST_N, RUN, HOLD, SPEED_UP, LEVEL_CLR;
    logic [7:0] LEDS;
    logic       STEP;
    logic [2:0] LEVEL;

    led_sweep #(.DIV_BASE(DIV_BASE), .LEVELS(LEVELS)) dut (
        .CLK(clk), .RST_N(RST_N), .RUN(RUN), .HOLD(HOLD), .SPEED_UP(SPEED_UP),
        .LEVEL_CLR(LEVEL_CLR), .LEDS(LEDS), .STEP(STEP), .LEVEL(LEVEL)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int         e;
        logic [7:0] leds;
        logic [2:0] lvl;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // reference model: sequence index plus the absolute edge of the next step
    bit m_active = 0;
    int m_idx    = 0;
    int m_lvl    = 0;
    int m_next   = 0;

    function automatic int per(input int l);
        int p;
        p = DIV_BASE >> l;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int pos_of(input int idx);
        return (idx < 8) ? idx : 14 - idx;
    endfunction

    task automatic model_edge(input bit rst, input bit run, input bit hold, input bit su, input bit clr);
        int   e;
        int   nl;
        exp_t x;
        e = edge_no + 1;
        if (!rst) begin
            m_active = 0; m_idx = 0; m_lvl = 0;
            return;
        end
        nl = clr ? 0 : (su ? ((m_lvl + 1 > LEVELS - 1) ? LEVELS - 1 : m_lvl + 1) : m_lvl);
        if (!run) begin
            m_active = 0; m_idx = 0;
        end else if (!m_active) begin
            m_active = 1; m_next = e + per(nl);
        end else if (hold) begin
            m_next = m_next + 1;
        end else if (e == m_next) begin
            m_idx  = (m_idx + 1) % SEQ;
            x.e    = e;
            x.leds = 8'(1 << pos_of(m_idx));
            x.lvl  = 3'(nl);
            q.push_back(x);
            m_next = e + per(nl);
        end else if (su || clr) begin
            m_next = e + per(nl);
        end
        m_lvl = nl;
    endtask

    task automatic step_cyc(input bit rst, input bit run, input bit hold, input bit su, input bit clr);
        RST_N = rst; RUN = run; HOLD = hold; SPEED_UP = su; LEVEL_CLR = clr;
        model_edge(rst, run, hold, su, clr);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    logic [7:0] prev_leds = 8'h01;
    exp_t       mx;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].e < edge_no) begin
            mx = q.pop_front();
            total++; bad++;
            $display("FAIL missed_step edge=%0d got STEP=0 want STEP=1 leds=%h", mx.e, mx.leds);
        end
        if (STEP === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL extra_step edge=%0d got STEP=1 leds=%h want no step", edge_no, LEDS);
            end else begin
                mx = q.pop_front();
                if (mx.e != edge_no || mx.leds !== LEDS || mx.lvl !== LEVEL) begin
                    bad++;
                    $display("FAIL step edge=%0d got leds=%h lvl=%0d want edge=%0d leds=%h lvl=%0d",
                             edge_no, LEDS, LEVEL, mx.e, mx.leds, mx.lvl);
                end
            end
        end else begin
            total++;
            if (LEDS !== prev_leds && LEDS !== 8'h01) begin
                bad++;
                $display("FAIL leds_stable edge=%0d got=%h want=%h", edge_no, LEDS, prev_leds);
            end
        end
        total++;
        if (!$onehot(LEDS)) begin
            bad++;
            $display("FAIL onehot edge=%0d got=%h want one-hot", edge_no, LEDS);
        end
        prev_leds = LEDS;
    end

    logic [7:0] hold_leds;
    int         guard;
    int         lvl_before;
    bit         rr, rh, rs, rc;

    initial begin
        RST_N = 0; RUN = 0; HOLD = 0; SPEED_UP = 0; LEVEL_CLR = 0;
        repeat (3) step_cyc(0, 0, 0, 0, 0);
        repeat (20) step_cyc(1, 0, 0, 0, 0);
        check("rst_leds", 32'(LEDS), 32'h01);
        check("rst_step", 32'(STEP), 32'h0);
        check("rst_level", 32'(LEVEL), 32'h0);

        repeat (8 * 16) step_cyc(1, 1, 0, 0, 0);

        repeat (3) step_cyc(1, 1, 0, 0, 0);
        hold_leds = LEDS;
        repeat (5) begin
            step_cyc(1, 1, 1, 0, 0);
            check("hold_leds", 32'(LEDS), 32'(hold_leds));
        end
        repeat (20) step_cyc(1, 1, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            step_cyc(1, 1, 0, 1, 0);
            check("level_up", 32'(LEVEL), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            repeat (24) step_cyc(1, 1, 0, 0, 0);
        end
        step_cyc(1, 1, 0, 0, 1);
        check("level_clr", 32'(LEVEL), 32'd0);
        repeat (40) step_cyc(1, 1, 0, 0, 0);
        step_cyc(1, 1, 0, 1, 1);
        check("clr_beats_su", 32'(LEVEL), 32'd0);
        step_cyc(1, 1, 0, 1, 0);
        check("level_one", 32'(LEVEL), 32'd1);

        guard = 0;
        while (!(m_active && m_idx == 5 && m_next == edge_no + 1) && guard < 400) begin
            step_cyc(1, 1, 0, 0, 0);
            guard++;
        end
        total++;
        if (guard >= 400) begin
            bad++;
            $display("FAIL drop_setup got=timeout want=position 5 with step due");
        end
        lvl_before = m_lvl;
        step_cyc(1, 0, 0, 0, 0);
        check("drop_leds", 32'(LEDS), 32'h01);
        check("drop_step", 32'(STEP), 32'h0);
        check("drop_level", 32'(LEVEL), 32'(lvl_before));
        repeat (3) step_cyc(1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 63) != 0);
            rh = ($urandom_range(0, 7) == 0);
            rs = !rh && ($urandom_range(0, 47) == 0);
            rc = !rh && ($urandom_range(0, 39) == 0);
            step_cyc(1, rr, rh, rs, rc);
        end

        repeat (20) step_cyc(1, 0, 0, 0, 0);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
